// File: rtl/dense_layer_seq.sv
// Sequential dense (fully-connected) layer: int8 activations x int8 weights,
// LANES neurons accumulated in parallel, one input feature per cycle.
// Requantisation is an arithmetic right shift by SHIFT, then saturation to int8.
// Optional build macro DENSE_LAYER_RELU_EN clamps negative results to zero
// before saturation; without it the outputs are signed int8.
module dense_layer_seq #(
  parameter int unsigned IN_FEATURES  = 128,
  parameter int unsigned OUT_FEATURES = 64,
  parameter int unsigned LANES        = 8,
  parameter int unsigned ACC_W        = 24,
  parameter int unsigned SHIFT        = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [IN_FEATURES*8-1:0]                   data_in,
  input  logic                                       data_in_valid,
  output logic                                       data_in_ready,
  input  logic                                       w_wr_en,
  input  logic [$clog2(OUT_FEATURES*IN_FEATURES)-1:0] w_addr,
  input  logic [7:0]                                 w_data,
  output logic [OUT_FEATURES*8-1:0]                  data_out,
  output logic                                       data_out_valid,
  input  logic                                       data_out_ready,
  output logic                                       busy
);

  localparam int unsigned Groups = OUT_FEATURES / LANES;
  localparam int unsigned Depth  = OUT_FEATURES * IN_FEATURES;
  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned KW     = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
  localparam int unsigned GW     = (Groups > 1) ? $clog2(Groups) : 1;

  typedef enum logic [1:0] {StIdle, StCompute, StOutput} state_e;

  state_e state_q, state_d;

  logic [KW-1:0]               k_q, k_d;
  logic [GW-1:0]               g_q, g_d;
  logic [IN_FEATURES*8-1:0]    x_q, x_d;
  logic [OUT_FEATURES*8-1:0]   dout_q, dout_d;
  logic signed [ACC_W-1:0]     acc_q [LANES];
  logic signed [ACC_W-1:0]     acc_d [LANES];
  logic signed [ACC_W-1:0]     acc_sum [LANES];
  logic signed [15:0]          prod [LANES];
  logic [7:0]                  w_rd [LANES];
  logic [AddrW-1:0]            rd_addr [LANES];
  logic signed [7:0]           x_k;
  logic                        last_k, last_g;

  // Weight storage; deliberately outside the reset domain so weights survive reset.
  logic [7:0] w_mem [Depth];

  // Shift, optional ReLU, then saturate to int8.
  function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic [ACC_W-8:0]        hi;
    s = a >>> SHIFT;
`ifdef DENSE_LAYER_RELU_EN
    if (s < 0) s = '0;
`endif
    hi = s[ACC_W-1:7];
    // In range when the top bits are a pure sign extension of bit 7.
    if ((&hi) || !(|hi)) begin
      requant = s[7:0];
    end else begin
      requant = s[ACC_W-1] ? 8'h80 : 8'h7f;
    end
  endfunction

  assign last_k   = (k_q == KW'(IN_FEATURES - 1));
  assign last_g   = (g_q == GW'(Groups - 1));
  assign data_out = dout_q;

  // Weight write port: only honoured while idle.
  always_ff @(posedge clk) begin
    if (w_wr_en && (state_q == StIdle) && (32'(w_addr) < Depth)) begin
      w_mem[w_addr] <= w_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (data_in_valid) state_d = StCompute;
      StCompute: if (last_k && last_g) state_d = StOutput;
      StOutput:  if (data_out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    data_in_ready  = (state_q == StIdle);
    busy           = (state_q != StIdle);
    data_out_valid = (state_q == StOutput);
  end

  // Per-lane weight fetch and MAC for the current (group, feature) pair.
  always_comb begin
    x_k = x_q[int'(k_q)*8 +: 8];
    for (int l = 0; l < int'(LANES); l++) begin
      rd_addr[l] = AddrW'((int'(g_q) * int'(LANES) + l) * int'(IN_FEATURES) + int'(k_q));
      w_rd[l]    = w_mem[rd_addr[l]];
      prod[l]    = x_k * $signed(w_rd[l]);
      acc_sum[l] = acc_q[l] + ACC_W'(prod[l]);
    end
  end

  // Datapath next-state: capture, accumulate, and group write-back.
  always_comb begin
    k_d    = k_q;
    g_d    = g_q;
    x_d    = x_q;
    dout_d = dout_q;
    for (int l = 0; l < int'(LANES); l++) acc_d[l] = acc_q[l];
    case (state_q)
      StIdle: begin
        if (data_in_valid) begin
          x_d = data_in;
          k_d = '0;
          g_d = '0;
          for (int l = 0; l < int'(LANES); l++) acc_d[l] = '0;
        end
      end
      StCompute: begin
        if (last_k) begin
          // Final feature of this group: fold in the current product and write back.
          for (int l = 0; l < int'(LANES); l++) begin
            dout_d[(int'(g_q) * int'(LANES) + l) * 8 +: 8] = requant(acc_sum[l]);
            acc_d[l] = '0;
          end
          k_d = '0;
          g_d = last_g ? '0 : g_q + 1'b1;
        end else begin
          for (int l = 0; l < int'(LANES); l++) acc_d[l] = acc_sum[l];
          k_d = k_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= '0;
      g_q    <= '0;
      x_q    <= '0;
      dout_q <= '0;
      for (int l = 0; l < int'(LANES); l++) acc_q[l] <= '0;
    end else begin
      k_q    <= k_d;
      g_q    <= g_d;
      x_q    <= x_d;
      dout_q <= dout_d;
      for (int l = 0; l < int'(LANES); l++) acc_q[l] <= acc_d[l];
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench for dense_layer_seq: small configuration (4x4, 2 lanes)
// plus a second instance with SHIFT=2 for requantisation rounding.
module tb_dense_layer_seq;

  localparam int IN  = 4;
  localparam int OUT = 4;
  localparam int LN  = 2;
  localparam int AW  = $clog2(OUT * IN);
  localparam int OUT2 = 2;
  localparam int AW2  = $clog2(OUT2 * IN);

  logic            clk, rst;
  logic [IN*8-1:0] data_in;
  logic            data_in_valid, data_in_ready;
  logic            w_wr_en;
  logic [AW-1:0]   w_addr;
  logic [7:0]      w_data;
  logic [OUT*8-1:0] data_out;
  logic            data_out_valid, data_out_ready, busy;

  logic [IN*8-1:0]   d2_data_in;
  logic              d2_data_in_valid, d2_data_in_ready;
  logic              d2_w_wr_en;
  logic [AW2-1:0]    d2_w_addr;
  logic [7:0]        d2_w_data;
  logic [OUT2*8-1:0] d2_data_out;
  logic              d2_data_out_valid, d2_data_out_ready, d2_busy;

  int checks = 0;
  int errors = 0;
  int wm [OUT][IN];

  localparam logic [31:0] XId = 32'h6407FD05;  // {100, 7, -3, 5}
`ifdef DENSE_LAYER_RELU_EN
  localparam logic [31:0] YId = 32'h64070005;
`else
  localparam logic [31:0] YId = 32'h6407FD05;
`endif

  dense_layer_seq #(
    .IN_FEATURES(IN), .OUT_FEATURES(OUT), .LANES(LN), .ACC_W(24), .SHIFT(0)
  ) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .busy(busy)
  );

  dense_layer_seq #(
    .IN_FEATURES(IN), .OUT_FEATURES(OUT2), .LANES(2), .ACC_W(24), .SHIFT(2)
  ) u_dut_shift (
    .clk(clk), .rst(rst), .data_in(d2_data_in), .data_in_valid(d2_data_in_valid),
    .data_in_ready(d2_data_in_ready), .w_wr_en(d2_w_wr_en), .w_addr(d2_w_addr),
    .w_data(d2_w_data), .data_out(d2_data_out), .data_out_valid(d2_data_out_valid),
    .data_out_ready(d2_data_out_ready), .busy(d2_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: dot product, arithmetic shift, optional ReLU, clamp to int8.
  function automatic logic [OUT*8-1:0] model(input logic [IN*8-1:0] x, input int shift);
    logic [OUT*8-1:0] y;
    int acc, r;
    for (int o = 0; o < OUT; o++) begin
      acc = 0;
      for (int i = 0; i < IN; i++) acc += int'($signed(x[i*8 +: 8])) * wm[o][i];
      r = acc >>> shift;
`ifdef DENSE_LAYER_RELU_EN
      if (r < 0) r = 0;
`endif
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      y[o*8 +: 8] = 8'(r);
    end
    return y;
  endfunction

  task automatic write_w(input int o, input int i, input int v);
    @(negedge clk);
    w_wr_en = 1'b1;
    w_addr  = AW'(o * IN + i);
    w_data  = 8'(v);
    @(posedge clk);
    #1 w_wr_en = 1'b0;
    wm[o][i] = 32'(signed'(8'(v)));
  endtask

  task automatic set_identity();
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++) write_w(o, i, (o == i) ? 1 : 0);
  endtask

  // Count rising edges after the accepting edge until data_out_valid (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!data_out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic send_and_wait(input logic [IN*8-1:0] x, output int lat);
    @(negedge clk);
    data_in = x;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    wait_valid(lat);
  endtask

  task automatic consume();
    @(negedge clk);
    data_out_ready = 1'b1;
    @(posedge clk);
    #1 data_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b busy=%b, required 0 0", data_out_valid, busy);
    end
    checks++;
    if (data_out !== '0) begin
      errors++;
      $display("FAIL reset_data_out: got %h, required 0", data_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", data_in_ready);
    end
  endtask

  task automatic test_identity();
    int lat;
    set_identity();
    send_and_wait(XId, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL identity_latency: got %0d edges, required 8", lat);
    end
    checks++;
    if (data_out !== YId || data_out !== model(XId, 0)) begin
      errors++;
      $display("FAIL identity_data: got %h, required %h", data_out, YId);
    end
    checks++;
    if (busy !== 1'b1 || data_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL output_flags: busy=%b ready=%b, required 1 0", busy, data_in_ready);
    end
    consume();
    checks++;
    if (data_in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: ready=%b busy=%b, required 1 0", data_in_ready, busy);
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [31:0] exp_neg;
`ifdef DENSE_LAYER_RELU_EN
    exp_neg = 32'h00000000;
`else
    exp_neg = 32'h80808080;
`endif
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++) write_w(o, i, 127);
    send_and_wait(32'h7f7f7f7f, lat);
    checks++;
    if (data_out !== 32'h7f7f7f7f) begin
      errors++;
      $display("FAIL sat_pos: got %h, required 7f7f7f7f", data_out);
    end
    consume();
    send_and_wait(32'h80808080, lat);
    checks++;
    if (data_out !== exp_neg) begin
      errors++;
      $display("FAIL sat_neg: got %h, required %h", data_out, exp_neg);
    end
    consume();
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] x, exp;
    for (int it = 0; it < 8; it++) begin
      for (int o = 0; o < OUT; o++)
        for (int i = 0; i < IN; i++)
          write_w(o, i, (it % 2 == 0) ? int'($urandom_range(0, 15)) - 8 : int'($urandom));
      for (int i = 0; i < IN; i++)
        x[i*8 +: 8] = (it % 2 == 0) ? 8'(int'($urandom_range(0, 15)) - 8) : 8'($urandom);
      exp = model(x, 0);
      send_and_wait(x, lat);
      checks++;
      if (lat !== 8 || data_out !== exp) begin
        errors++;
        $display("FAIL random_%0d: got %h after %0d edges, required %h after 8",
                 it, data_out, lat, exp);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] held;
    set_identity();
    send_and_wait(XId, lat);
    held = data_out;
    checks++;
    if (held !== YId) begin
      errors++;
      $display("FAIL bp_result: got %h, required %h", held, YId);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      data_in = ~XId;
      data_in_valid = (c % 3 == 0);
      @(posedge clk);
      #1;
      checks++;
      if (data_out !== held || data_out_valid !== 1'b1 || data_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out=%h valid=%b ready=%b, required %h 1 0",
                 c, data_out, data_out_valid, data_in_ready, held);
      end
    end
    data_in_valid = 1'b0;
    consume();
    checks++;
    if (data_in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ready=%b busy=%b, required 1 0", data_in_ready, busy);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (data_out_valid !== 1'b0 || busy !== 1'b0 || data_out !== held) begin
      errors++;
      $display("FAIL bp_no_queue: valid=%b busy=%b out=%h, required 0 0 %h",
               data_out_valid, busy, data_out, held);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    data_in = XId;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b out=%h busy=%b, required 0 0 0",
               data_out_valid, data_out, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_abort: valid=%b ready=%b, required 0 1", data_out_valid, data_in_ready);
    end
    send_and_wait(XId, lat);
    checks++;
    if (lat !== 8 || data_out !== YId) begin
      errors++;
      $display("FAIL mid_resend: got %h after %0d edges, required %h after 8", data_out, lat, YId);
    end
    consume();
  endtask

  task automatic test_weight_write();
    int lat;
    logic [31:0] exp;
    // Write attempted while busy: must be dropped (model untouched).
    @(negedge clk);
    data_in = XId;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    @(negedge clk);
    w_wr_en = 1'b1;
    w_addr  = '0;
    w_data  = 8'd9;
    @(posedge clk);
    #1 w_wr_en = 1'b0;
    wait_valid(lat);
    checks++;
    if (data_out !== YId) begin
      errors++;
      $display("FAIL busy_write_cur: got %h, required %h", data_out, YId);
    end
    consume();
    send_and_wait(XId, lat);
    checks++;
    if (data_out !== YId) begin
      errors++;
      $display("FAIL busy_write_next: got %h, required %h", data_out, YId);
    end
    consume();
    write_w(0, 0, 9);
    send_and_wait(XId, lat);
    checks++;
    if (data_out[7:0] !== 8'd45 || data_out !== model(XId, 0)) begin
      errors++;
      $display("FAIL idle_write: got %h, required low byte 2d", data_out);
    end
    consume();
    // Write and accept on the same edge: the new vector sees the new weight.
    @(negedge clk);
    w_wr_en = 1'b1;
    w_addr  = '0;
    w_data  = 8'd2;
    data_in = XId;
    data_in_valid = 1'b1;
    wm[0][0] = 2;
    exp = model(XId, 0);
    @(posedge clk);
    #1;
    w_wr_en = 1'b0;
    data_in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (data_out[7:0] !== 8'd10 || data_out !== exp) begin
      errors++;
      $display("FAIL same_edge_write: got %h, required %h", data_out, exp);
    end
    consume();
  endtask

  task automatic d2_run(input logic [31:0] x, input logic [15:0] exp, input string name);
    int lat;
    @(negedge clk);
    d2_data_in = x;
    d2_data_in_valid = 1'b1;
    @(posedge clk);
    #1 d2_data_in_valid = 1'b0;
    lat = 0;
    while (!d2_data_out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (lat !== 4 || d2_data_out !== exp) begin
      errors++;
      $display("FAIL %s: got %h after %0d edges, required %h after 4", name, d2_data_out, lat, exp);
    end
    @(negedge clk);
    d2_data_out_ready = 1'b1;
    @(posedge clk);
    #1 d2_data_out_ready = 1'b0;
  endtask

  task automatic test_shift();
    logic [15:0] exp_neg;
`ifdef DENSE_LAYER_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'h00FD;
`endif
    for (int a = 0; a < OUT2 * IN; a++) begin
      @(negedge clk);
      d2_w_wr_en = 1'b1;
      d2_w_addr  = AW2'(a);
      d2_w_data  = (a == 0) ? 8'd10 : 8'd0;
      @(posedge clk);
      #1 d2_w_wr_en = 1'b0;
    end
    d2_run(32'h00000001, 16'h0002, "shift_pos");
    d2_run(32'h000000FF, exp_neg, "shift_neg");
  endtask

  initial begin
    data_in = '0;
    data_in_valid = 1'b0;
    w_wr_en = 1'b0;
    w_addr = '0;
    w_data = '0;
    data_out_ready = 1'b0;
    d2_data_in = '0;
    d2_data_in_valid = 1'b0;
    d2_w_wr_en = 1'b0;
    d2_w_addr = '0;
    d2_w_data = '0;
    d2_data_out_ready = 1'b0;
    rst = 1'b0;
    test_reset();
    test_identity();
    test_saturation();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_weight_write();
    test_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
